// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb_if
//  Description : Read, write, issue and status signals of the scoreboarded
//                register file. The register file is the slave; the
//                issue/writeback logic driving it is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] r1_addr;
    logic [ADDR_W-1:0] r2_addr;
    logic [DATA_W-1:0] r1_data;
    logic [DATA_W-1:0] r2_data;
    logic              r1_busy;
    logic              r2_busy;
    logic              we0;
    logic [ADDR_W-1:0] w0_addr;
    logic [DATA_W-1:0] w0_data;
    logic              we1;
    logic [ADDR_W-1:0] w1_addr;
    logic [DATA_W-1:0] w1_data;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              wr_conflict;

    modport master (
        output r1_addr, r2_addr, we0, w0_addr, w0_data,
               we1, w1_addr, w1_data, iss_valid, iss_addr,
        input  r1_data, r2_data, r1_busy, r2_busy, wr_conflict
    );

    modport slave (
        input  r1_addr, r2_addr, we0, w0_addr, w0_data,
               we1, w1_addr, w1_data, iss_valid, iss_addr,
        output r1_data, r2_data, r1_busy, r2_busy, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Two-write, two-read register file with optional same-cycle
//                write-to-read bypass and a per-register busy scoreboard for
//                in-order issue with multi-cycle producers.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int REG_N    = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clock,
    input  logic         n_rst,
    reg_file_sb_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_zero_addr = '0;

    logic [DATA_W-1:0] r_regs [REG_N];
    logic [REG_N-1:0]  r_busy;
    logic              r_wr_conflict;

    logic              w_w0_eff;
    logic              w_w1_eff;
    logic              w_r1_hit0;
    logic              w_r1_hit1;
    logic              w_r2_hit0;
    logic              w_r2_hit1;
    logic [DATA_W-1:0] w_r1_data;
    logic [DATA_W-1:0] w_r2_data;
    logic              w_r1_busy;
    logic              w_r2_busy;

    // A write is effective unless it targets the hard-wired zero register.
    assign w_w0_eff = bus.we0 && !((ZERO_REG != 0) && (bus.w0_addr == c_zero_addr));
    assign w_w1_eff = bus.we1 && !((ZERO_REG != 0) && (bus.w1_addr == c_zero_addr));

    assign w_r1_hit0 = w_w0_eff && (bus.w0_addr == bus.r1_addr);
    assign w_r1_hit1 = w_w1_eff && (bus.w1_addr == bus.r1_addr);
    assign w_r2_hit0 = w_w0_eff && (bus.w0_addr == bus.r2_addr);
    assign w_r2_hit1 = w_w1_eff && (bus.w1_addr == bus.r2_addr);

    // Register storage: W0 wins over W1 when both target the same register.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < REG_N; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < REG_N; k++) begin
                if (w_w0_eff && (bus.w0_addr == ADDR_W'(k))) begin
                    r_regs[k] <= bus.w0_data;
                end else if (w_w1_eff && (bus.w1_addr == ADDR_W'(k))) begin
                    r_regs[k] <= bus.w1_data;
                end
            end
        end
    end

    // Scoreboard: a new issue takes precedence over a retiring write.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < REG_N; k++) begin
                if (bus.iss_valid && (bus.iss_addr == ADDR_W'(k)) &&
                    !((ZERO_REG != 0) && (k == 0))) begin
                    r_busy[k] <= 1'b1;
                end else if ((w_w0_eff && (bus.w0_addr == ADDR_W'(k))) ||
                             (w_w1_eff && (bus.w1_addr == ADDR_W'(k)))) begin
                    r_busy[k] <= 1'b0;
                end
            end
        end
    end

    // Flag that W1 data was dropped because W0 wrote the same register.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_w0_eff && w_w1_eff && (bus.w0_addr == bus.w1_addr);
        end
    end

    // Read port 1: stored value, optionally overridden by same-cycle writes.
    always_comb begin
        w_r1_data = r_regs[bus.r1_addr];
        w_r1_busy = r_busy[bus.r1_addr];
        if (BYPASS != 0) begin
            if (w_r1_hit0) begin
                w_r1_data = bus.w0_data;
            end else if (w_r1_hit1) begin
                w_r1_data = bus.w1_data;
            end
            w_r1_busy = r_busy[bus.r1_addr] && !(w_r1_hit0 || w_r1_hit1);
        end
        if ((ZERO_REG != 0) && (bus.r1_addr == c_zero_addr)) begin
            w_r1_data = '0;
            w_r1_busy = 1'b0;
        end
    end

    // Read port 2: same behaviour as read port 1.
    always_comb begin
        w_r2_data = r_regs[bus.r2_addr];
        w_r2_busy = r_busy[bus.r2_addr];
        if (BYPASS != 0) begin
            if (w_r2_hit0) begin
                w_r2_data = bus.w0_data;
            end else if (w_r2_hit1) begin
                w_r2_data = bus.w1_data;
            end
            w_r2_busy = r_busy[bus.r2_addr] && !(w_r2_hit0 || w_r2_hit1);
        end
        if ((ZERO_REG != 0) && (bus.r2_addr == c_zero_addr)) begin
            w_r2_data = '0;
            w_r2_busy = 1'b0;
        end
    end

    assign bus.r1_data     = w_r1_data;
    assign bus.r2_data     = w_r2_data;
    assign bus.r1_busy     = w_r1_busy;
    assign bus.r2_busy     = w_r2_busy;
    assign bus.wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file that succeeds the single-write, two-read distributed-RAM file. It has two synchronous write ports (W0 for ALU writeback, W1 for load writeback) and two asynchronous read ports with optional write-to-read bypass. A per-register busy scoreboard supports a simple in-order issue stage with multi-cycle producers. It sits between decode/issue and writeback in the CPU core.

Parameters:
DATA_W, 16, register data width in bits
REG_N, 16, number of registers (power of two, at least 2)
ADDR_W, 4, register address width (equals log2(REG_N))
BYPASS, 1, when 1, reads return same-cycle write data; when 0, reads return stored data only
ZERO_REG, 1, when 1, register 0 is hard-wired zero

Ports:
clock  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-low
r1_addr  in  ADDR_W  read port 1 address
r2_addr  in  ADDR_W  read port 2 address
r1_data  out  DATA_W  read port 1 data (combinational)
r2_data  out  DATA_W  read port 2 data (combinational)
r1_busy  out  1  register at r1_addr has an outstanding producer
r2_busy  out  1  register at r2_addr has an outstanding producer
we0  in  1  write enable, port W0
w0_addr  in  ADDR_W  write address, W0
w0_data  in  DATA_W  write data, W0
we1  in  1  write enable, port W1
w1_addr  in  ADDR_W  write address, W1
w1_data  in  DATA_W  write data, W1
iss_valid  in  1  issue of an instruction that writes a destination register
iss_addr  in  ADDR_W  destination register of the issued instruction
wr_conflict  out  1  registered flag: W0 and W1 targeted the same register in the previous cycle

Behaviour:
- Reset (n_rst low, asynchronous): all REG_N registers cleared to 0, all busy bits cleared, wr_conflict=0. This differs from the predecessor, which cleared only register 0.
- Writes take effect at the rising clock edge. A write is effective when weX=1 and the address is not 0 (the zero check applies only when ZERO_REG=1).
- Both ports effective on the same address: W0 data is stored, W1 data is dropped, and wr_conflict=1 in the following cycle. Otherwise wr_conflict=0 in the following cycle.
- Both ports effective on different addresses: both registers are written in the same edge.
- Read, BYPASS=0: rX_data = stored value at rX_addr.
- Read, BYPASS=1: if an effective W0 write matches rX_addr, rX_data = w0_data. Otherwise, if an effective W1 write matches, rX_data = w1_data. Otherwise rX_data = the stored value. The path is purely combinational, with zero latency.
- ZERO_REG=1: reading address 0 always returns 0 and reports busy=0, regardless of any bypass.
- Scoreboard, per-register busy bit, evaluated at each edge for register k:
  - set if iss_valid=1 and iss_addr=k (and k is not 0 when ZERO_REG=1);
  - else cleared if any effective write to k occurs;
  - else held.
- Issue and write to the same register in the same cycle: busy remains 1, because the new producer takes precedence.
- rX_busy, BYPASS=0: equals the stored busy bit.
- rX_busy, BYPASS=1: equals stored busy AND NOT (an effective write to rX_addr this cycle). The consumer can therefore issue in the writeback cycle.
- An issue to a register that is already busy (WAW) is legal, and the bit stays set. Writes to a non-busy register are legal and do not change the busy bit.
- Reset asserted mid-operation: all state returns to reset values immediately. Writes presented in that cycle are lost.

Test Plan:
- Reset, then read r1=3 and r2=15 -> both data outputs 0 and both busy 0. Write W0 addr 3 = 0x1234, then read r1=3 next cycle -> 0x1234.
- ZERO_REG=1: write W0 addr 0 = 0xFFFF and iss addr 0 -> read addr 0 gives 0, busy=0, wr_conflict=0.
- BYPASS=1: we0 addr 5 = 0xAAAA with r1_addr=5 in the same cycle -> r1_data=0xAAAA combinationally. With BYPASS=0, same stimulus -> old value 0, then 0xAAAA next cycle.
- Conflict: we0 addr 7 = 0x1111 and we1 addr 7 = 0x2222 together -> reg 7 = 0x1111, wr_conflict=1 for exactly one cycle. With different addresses 6/7 -> both written, wr_conflict=0.
- Scoreboard: iss addr 9 -> r1_busy(9)=1 from the next cycle. On the cycle we1 writes addr 9 = 0x0042 (BYPASS=1) -> r1_busy=0 and r1_data=0x0042. The stored busy bit clears on that edge.
- Simultaneous iss addr 4 and we0 addr 4 -> busy(4)=1 afterwards. Asserting n_rst low mid-sequence -> all busy bits and registers 0 immediately.
